// File: rtl/cia_timer_pkg.sv
// Shared constants for the CIA-style timer bank: control register layout,
// input-mode encodings and register map.
package cia_timer_pkg;
  localparam int CR_START   = 0;
  localparam int CR_PBON    = 1;
  localparam int CR_OUTMODE = 2;
  localparam int CR_RUNMODE = 3;
  localparam int CR_LOAD    = 4;

  localparam logic [2:0] REG_CR = 3'd7;

  typedef enum logic [1:0] {
    INMODE_ECLK     = 2'b00,
    INMODE_CNT      = 2'b01,
    INMODE_CASC     = 2'b10,
    INMODE_CASC_CNT = 2'b11
  } inmode_e;

  // LOAD is a strobe and bit 7 is unimplemented, so neither is ever stored
  function automatic logic [7:0] cr_store(input logic [7:0] d);
    return {1'b0, d[6:5], 1'b0, d[3:0]};
  endfunction
endpackage

// File: rtl/cia_timer_chain_if.sv
// CPU register port of the timer bank.
interface cia_timer_chain_if;
  logic       wr;
  logic       cs;
  logic [1:0] ch_sel;
  logic [2:0] reg_sel;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output wr, cs, ch_sel, reg_sel, data_in, input data_out);
  modport slave  (input wr, cs, ch_sel, reg_sel, data_in, output data_out);
endinterface

// File: rtl/cia_timer_chan.sv
// One timer channel: latch, control register, down-counter, underflow irq
// and PB pulse/toggle output.
module cia_timer_chan
  import cia_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk7_en,
  input  logic             we,
  input  logic [2:0]       reg_sel,
  input  logic [7:0]       data_in,
  input  logic             eclk,
  input  logic             cnt,
  input  logic             cnt_rise,
  input  logic             casc_in,
  output logic             uf,
  output logic [WIDTH-1:0] counter,
  output logic [7:0]       cr,
  output logic             irq,
  output logic             pb_out
);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] latch;
  logic             force_ld, armed, tog;
  logic             count, cr_we, top_we, load_now;
  logic [7:0]       cr_nxt;
  inmode_e          inmode;

  assign inmode = inmode_e'(cr[6:5]);

  always_comb begin
    count = 1'b0;
    case (inmode)
      INMODE_ECLK: count = eclk;
      INMODE_CNT:  count = cnt_rise;
      INMODE_CASC: count = casc_in;
      default:     count = casc_in & cnt;
    endcase
  end

  assign uf       = (counter == '0) & cr[CR_START] & count;
  assign cr_we    = we & (reg_sel == REG_CR);
  assign top_we   = we & (reg_sel == 3'(NB - 1));
  assign load_now = force_ld | (armed & eclk) | uf;

  // CPU write to CR overrides both one-shot stop and top-byte auto start
  always_comb begin
    cr_nxt = cr;
    if (uf && cr[CR_RUNMODE])     cr_nxt[CR_START] = 1'b0;
    if (top_we && cr[CR_RUNMODE]) cr_nxt[CR_START] = 1'b1;
    if (cr_we)                    cr_nxt = cr_store(data_in);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch    <= '1;
      counter  <= '1;
      cr       <= '0;
      force_ld <= 1'b0;
      armed    <= 1'b0;
      tog      <= 1'b0;
      irq      <= 1'b0;
    end else if (clk7_en) begin
      cr       <= cr_nxt;
      irq      <= uf;
      force_ld <= cr_we & data_in[CR_LOAD];
      for (int b = 0; b < NB; b++)
        if (we && reg_sel == 3'(b)) latch[8*b +: 8] <= data_in;
      if (top_we && (!cr[CR_START] || cr[CR_RUNMODE])) armed <= 1'b1;
      else if (eclk)                                   armed <= 1'b0;
      if (load_now)                   counter <= latch;
      else if (cr[CR_START] && count) counter <= counter - 1'b1;
      if (cr_nxt[CR_START] && !cr[CR_START]) tog <= 1'b1;
      else if (uf)                           tog <= ~tog;
    end
  end

  assign pb_out = cr[CR_PBON] & (cr[CR_OUTMODE] ? tog : irq);
endmodule

// File: rtl/cia_timer_chain.sv
// CIA-style timer bank: NUM_CH cascadable channels, shared CNT edge
// detector, CPU address decode and read mux.
module cia_timer_chain
  import cia_timer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk7_en,
  cia_timer_chain_if.slave    bus,
  input  logic                eclk,
  input  logic                cnt,
  output logic [NUM_CH-1:0]   irq,
  output logic [NUM_CH-1:0]   pb_out
);
  localparam int NB = WIDTH / 8;

  logic                           cnt_d, cnt_rise;
  logic [NUM_CH-1:0][WIDTH-1:0]   cnt_all;
  logic [NUM_CH-1:0][7:0]         cr_all;
  logic [7:0]                     rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt_d <= 1'b0;
    else if (clk7_en) cnt_d <= cnt;
  end
  assign cnt_rise = cnt & ~cnt_d;

  // Underflow ripples combinationally so a cascade counts in the same cycle
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic uf, casc, we;
    if (gi == 0) begin : g_first
      assign casc = 1'b0;
    end else begin : g_next
      assign casc = g_ch[gi-1].uf;
    end
    assign we = clk7_en & bus.cs & bus.wr & (bus.ch_sel == 2'(gi));

    cia_timer_chan #(.WIDTH(WIDTH)) u_chan (
      .clk      (clk),
      .reset    (reset),
      .clk7_en  (clk7_en),
      .we       (we),
      .reg_sel  (bus.reg_sel),
      .data_in  (bus.data_in),
      .eclk     (eclk),
      .cnt      (cnt),
      .cnt_rise (cnt_rise),
      .casc_in  (casc),
      .uf       (uf),
      .counter  (cnt_all[gi]),
      .cr       (cr_all[gi]),
      .irq      (irq[gi]),
      .pb_out   (pb_out[gi])
    );
  end

  always_comb begin
    rd = '0;
    if (bus.cs && !bus.wr)
      for (int c = 0; c < NUM_CH; c++)
        if (bus.ch_sel == 2'(c)) begin
          if (bus.reg_sel == REG_CR) rd = cr_all[c];
          for (int b = 0; b < NB; b++)
            if (bus.reg_sel == 3'(b)) rd = cnt_all[c][8*b +: 8];
        end
  end
  assign bus.data_out = rd;
endmodule
